// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter slice.
// Source indices name the default three producers; NO_LABEL marks "no producer".
package cdb_arbiter_pkg;

   localparam int unsigned LABEL_W_DEF = 4;
   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned NO_LABEL    = 0;

   localparam int unsigned SRC_ADD = 0;
   localparam int unsigned SRC_MUL = 1;
   localparam int unsigned SRC_LD  = 2;

   localparam int unsigned STAT_W = 16;

   // Saturating increment for the optional statistics counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of eligible at or after rr_ptr,
// wrapping modulo NUM_SRC (explicit wrap, so non-power-of-2 counts work).
module rr_pick
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned PTR_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] eligible,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_SRC-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               grant_vld
);

   always_comb begin
      int unsigned      cand;
      logic [PTR_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = 0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         cand = 32'(rr_ptr) + k;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         idx = PTR_W'(cand);
         if (!grant_vld && eligible[idx]) begin
            grant_vld  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter with a registered broadcast triple.
// Define CDB_STATS_EN to add saturating per-source grant and conflict counters.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned LABEL_W = LABEL_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
) (
   input  logic                       clk,
   input  logic                       nRST,
   input  logic [NUM_SRC-1:0]         req_valid,
   input  logic [NUM_SRC*LABEL_W-1:0] req_label,
   input  logic [NUM_SRC*DATA_W-1:0]  req_data,
   output logic [NUM_SRC-1:0]         req_grant,
   output logic                       BCEN,
   output logic [LABEL_W-1:0]         BClabel,
   output logic [DATA_W-1:0]          BCdata,
   output logic                       busy
`ifdef CDB_STATS_EN
   ,
   output logic [NUM_SRC*STAT_W-1:0]  stat_grants,
   output logic [STAT_W-1:0]          stat_conflict
`endif
);

   localparam int unsigned PTR_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] pick_grant;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_vld;
   logic               grant_vld;

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               bcen_q;
   logic [LABEL_W-1:0] bclabel_q, bclabel_d;
   logic [DATA_W-1:0]  bcdata_q, bcdata_d;

   // A valid request carrying tag 0 is a protocol error and is simply ignored.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         eligible[i] = req_valid[i] &&
                       (req_label[i*LABEL_W +: LABEL_W] != LABEL_W'(NO_LABEL));
      end
   end

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .grant_vld (pick_vld)
   );

   assign grant_vld = nRST && pick_vld;
   assign req_grant = nRST ? pick_grant : '0;
   assign busy      = |req_valid;

   always_comb begin
      bclabel_d = bclabel_q;
      bcdata_d  = bcdata_q;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (pick_grant[i]) begin
            bclabel_d = req_label[i*LABEL_W +: LABEL_W];
            bcdata_d  = req_data[i*DATA_W +: DATA_W];
         end
      end
      rr_ptr_d = rr_ptr_q;
      if (pick_vld) begin
         rr_ptr_d = (pick_idx == PTR_W'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         bcen_q    <= 1'b0;
         bclabel_q <= '0;
         bcdata_q  <= '0;
         rr_ptr_q  <= '0;
      end else begin
         bcen_q    <= grant_vld;
         bclabel_q <= bclabel_d;
         bcdata_q  <= bcdata_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign BCEN    = bcen_q;
   assign BClabel = bclabel_q;
   assign BCdata  = bcdata_q;

`ifdef CDB_STATS_EN
   logic [NUM_SRC*STAT_W-1:0] grants_q;
   logic [STAT_W-1:0]         conflict_q;
   logic                      conflict;

   assign conflict = $countones(eligible) > 1;

   always_ff @(posedge clk) begin
      if (!nRST) begin
         grants_q   <= '0;
         conflict_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pick_grant[i]) begin
               grants_q[i*STAT_W +: STAT_W] <= sat_inc(grants_q[i*STAT_W +: STAT_W]);
            end
         end
         if (conflict) conflict_q <= sat_inc(conflict_q);
      end
   end

   assign stat_grants   = grants_q;
   assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios then randomized traffic
// against a round-robin reference model; broadcasts are checked by a separate monitor.
module tb_cdb_arbiter;

   localparam int N  = 3;
   localparam int LW = 4;
   localparam int DW = 32;

   logic            clk;
   logic            nRST;
   logic [N-1:0]    req_valid;
   logic [N*LW-1:0] req_label;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_grant;
   logic            BCEN;
   logic [LW-1:0]   BClabel;
   logic [DW-1:0]   BCdata;
   logic            busy;
`ifdef CDB_STATS_EN
   logic [N*16-1:0] stat_grants;
   logic [15:0]     stat_conflict;
`endif

   cdb_arbiter #(
      .NUM_SRC (N),
      .LABEL_W (LW),
      .DATA_W  (DW)
   ) dut (
      .clk       (clk),
      .nRST      (nRST),
      .req_valid (req_valid),
      .req_label (req_label),
      .req_data  (req_data),
      .req_grant (req_grant),
      .BCEN      (BCEN),
      .BClabel   (BClabel),
      .BCdata    (BCdata),
      .busy      (busy)
`ifdef CDB_STATS_EN
      ,
      .stat_grants   (stat_grants),
      .stat_conflict (stat_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Applied source state (sv/slab/sdat) and the intent for the next cycle (nv/nlab/ndat).
   bit            sv[N];
   logic [LW-1:0] slab[N];
   logic [DW-1:0] sdat[N];
   bit            nv[N];
   logic [LW-1:0] nlab[N];
   logic [DW-1:0] ndat[N];

   always_comb begin
      req_valid = '0;
      req_label = '0;
      req_data  = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i]            = sv[i];
         req_label[i*LW +: LW]   = slab[i];
         req_data[i*DW +: DW]    = sdat[i];
      end
   end

   typedef struct {
      bit            rst;
      bit            en;
      logic [LW-1:0] lab;
      logic [DW-1:0] dat;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;

   int passed = 0;
   int total  = 0;

   // Reference model state.
   int           mptr = 0;
   bit [N-1:0]   mgrant = '0;
   int           mgr_cnt[N];
   int           mconf = 0;
   bit           stat_check_req = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else passed++;
   endtask

   task automatic set_src(input int i, input bit v, input logic [LW-1:0] l,
                          input logic [DW-1:0] d);
      nv[i]   = v;
      nlab[i] = l;
      ndat[i] = d;
   endtask

   task automatic step(input bit rst_n);
      int   win;
      int   ne;
      bit   bz;
      exp_t e;
      for (int i = 0; i < N; i++) begin
         if (nRST && rst_n && sv[i] && !mgrant[i] && slab[i] != '0)
            assert (nv[i] && nlab[i] == slab[i] && ndat[i] == sdat[i])
            else $error("stimulus broke holding rule on src %0d", i);
      end
      @(posedge clk);
      #1;
`ifdef CDB_STATS_EN
      if (stat_check_req) begin
         for (int i = 0; i < N; i++)
            chk($sformatf("stat_grants[%0d]", i), stat_grants[i*16 +: 16], mgr_cnt[i]);
         chk("stat_conflict", stat_conflict, mconf);
         stat_check_req = 0;
      end
`endif
      nRST = rst_n;
      for (int i = 0; i < N; i++) begin
         sv[i]   = nv[i];
         slab[i] = nlab[i];
         sdat[i] = ndat[i];
      end
      #1;
      win = -1;
      ne  = 0;
      bz  = 0;
      for (int k = 0; k < N; k++) begin
         int i = (mptr + k) % N;
         bz |= sv[i];
         if (sv[i] && slab[i] != '0) begin
            ne++;
            if (win < 0) win = i;
         end
      end
      if (!rst_n) win = -1;
      mgrant = '0;
      if (win >= 0) mgrant[win] = 1'b1;
      chk("req_grant", req_grant, mgrant);
      chk("busy", busy, bz);
      e.rst = !rst_n;
      e.en  = (win >= 0);
      e.lab = (win >= 0) ? slab[win] : '0;
      e.dat = (win >= 0) ? sdat[win] : '0;
      expq.push_back(e);
      if (!rst_n) begin
         mptr  = 0;
         mconf = 0;
         for (int i = 0; i < N; i++) mgr_cnt[i] = 0;
      end else begin
         if (win >= 0) begin
            mptr = (win + 1) % N;
            if (mgr_cnt[win] < 65535) mgr_cnt[win]++;
         end
         if (ne >= 2 && mconf < 65535) mconf++;
      end
   endtask

   // Drop granted and tag-0 requests until every source is idle.
   task automatic drain();
      for (int c = 0; c < N + 2; c++) begin
         for (int i = 0; i < N; i++) if (mgrant[i] || nlab[i] == '0) nv[i] = 0;
         step(1'b1);
      end
   endtask

   // Monitor: the broadcast seen after edge t+1 belongs to the entry pushed in cycle t.
   always @(negedge clk) begin
      if (expq.size() > 1) begin
         mon_e = expq.pop_front();
         chk("BCEN", BCEN, mon_e.en);
         if (mon_e.rst || mon_e.en) begin
            chk("BClabel", BClabel, mon_e.lab);
            chk("BCdata", BCdata, mon_e.dat);
         end
      end
   end

   initial begin
      nRST = 1'b0;
      for (int i = 0; i < N; i++) begin
         sv[i] = 0; slab[i] = '0; sdat[i] = '0;
         mgr_cnt[i] = 0;
      end
      // Reset with every source requesting.
      for (int i = 0; i < N; i++) set_src(i, 1, LW'(i + 1), DW'(32'h100 + i));
      step(1'b0);
      step(1'b0);
      // Round robin with all sources continuously valid.
      repeat (6) step(1'b1);
      drain();
      // Single requester.
      set_src(1, 1, 4'd5, 32'hDEADBEEF);
      step(1'b1);
      // Holding: pointer now at 2, so src2 wins and src0 waits one cycle.
      set_src(1, 0, '0, '0);
      set_src(0, 1, 4'd1, 32'd7);
      set_src(2, 1, 4'd3, 32'd9);
      step(1'b1);
      set_src(2, 0, '0, '0);
      step(1'b1);
      drain();
      // Tag-0 request is never granted.
      set_src(1, 1, 4'd0, 32'h55);
      repeat (3) step(1'b1);
      set_src(1, 0, '0, '0);
      set_src(0, 1, 4'd4, 32'h1234);
      step(1'b1);
      drain();
`ifdef CDB_STATS_EN
      // Three conflict cycles then two single-requester cycles: expect {2,2,1}, 3.
      step(1'b0);
      for (int i = 0; i < N; i++) set_src(i, 1, LW'(i + 1), DW'(i));
      step(1'b1);
      step(1'b1);
      set_src(1, 0, '0, '0);
      step(1'b1);
      set_src(2, 0, '0, '0);
      step(1'b1);
      set_src(0, 0, '0, '0);
      set_src(1, 1, 4'd2, 32'd77);
      step(1'b1);
      set_src(1, 0, '0, '0);
      step(1'b1);
      stat_check_req = 1;
      step(1'b1);
`endif
      // Randomized traffic with occasional mid-operation reset.
      for (int c = 0; c < 500; c++) begin
         bit r;
         r = ($urandom_range(0, 49) != 0);
         for (int i = 0; i < N; i++) begin
            if (!sv[i] || mgrant[i] || (slab[i] == '0 && $urandom_range(0, 2) == 0)) begin
               nv[i]   = ($urandom_range(0, 9) < 6);
               nlab[i] = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 15));
               ndat[i] = $urandom;
            end
         end
         step(r);
      end
      drain();
`ifdef CDB_STATS_EN
      stat_check_req = 1;
      step(1'b1);
`endif
      step(1'b1);
      step(1'b1);
      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the Common Data Bus (CDB) between NUM_SRC functional-unit result producers, e.g. add unit, mult unit, load buffer.
- Accepts at most one result per cycle, round-robin fair.
- Drives the registered broadcast triple (BCEN, BClabel, BCdata) into every reservation station and the register-status table.
- Losing requesters hold their result until granted.

Parameters:
- NUM_SRC, 3, number of requesting units (2..8).
- LABEL_W, 4, reservation-station tag width; tag 0 means "no producer".
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock
- nRST  in  1  synchronous active-low reset
- req_valid  in  NUM_SRC  per-source result valid
- req_label  in  NUM_SRC*LABEL_W  per-source tag; source i occupies bits [i*LABEL_W +: LABEL_W]
- req_data  in  NUM_SRC*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W]
- req_grant  out  NUM_SRC  one-hot, combinational; source i accepted this cycle
- BCEN  out  1  broadcast valid (registered)
- BClabel  out  LABEL_W  broadcast tag (registered)
- BCdata  out  DATA_W  broadcast value (registered)
- busy  out  1  OR of req_valid (combinational, for debug/stall logic)

Behaviour:
- Reset is synchronous: on a clk edge with nRST=0, BCEN=0, BClabel=0, BCdata=0, rr_ptr=0.
- During reset, req_grant=0 combinationally; nothing is accepted.
- rr_ptr (log2 NUM_SRC bits) is the highest-priority source.
  - Search order: rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_SRC (wrap is explicit for non-power-of-2 NUM_SRC).
- Eligible source: req_valid[i]=1 and its label != 0.
- Grant:
  - req_grant has exactly one bit set for the first eligible source in search order; all zeros if none is eligible.
  - The handshake completes in the same cycle as the grant. The source must drop or replace its request on the next cycle.
  - A source with req_valid=1 and no grant must keep label and data stable (holding rule; checked by bench assertion).
- Invalid tag: valid with label 0 is a protocol error.
  - Such a source is never granted and never broadcast.
  - The other sources are unaffected.
- Latency: a granted result appears on BCEN/BClabel/BCdata on the next clk edge and is held exactly one cycle.
  - Next edge with no grant: BCEN=0. BClabel/BCdata keep their last values (don't-care while BCEN=0).
- Pointer update: on a grant to source g, rr_ptr <= g+1 (wrapping to 0 after NUM_SRC-1). With no grant, rr_ptr is unchanged.
- Throughput: one broadcast per cycle sustained. A source re-requesting back-to-back waits at most NUM_SRC-1 cycles.
- Simultaneous events:
  - Any number of sources may request together; only one is granted per cycle.
  - A result granted in cycle t reaches the reservation stations at edge t+1. Stations capture it that cycle, including a same-cycle issue whose operand tag matches.
- Reset mid-operation: a pending broadcast register is cleared (BCEN=0) and that result is lost. Upstream units are reset by the same nRST.

Optional Feature:
- Macro CDB_STATS_EN.
- Defined:
  - Adds output stat_grants (NUM_SRC*16): one 16-bit saturating grant counter per source.
  - Adds output stat_conflict (16): saturating count of cycles with >=2 eligible requesters.
  - All counters clear on reset; they hold at 16'hFFFF once reached.
- Undefined: those ports and registers do not exist; the arbiter is otherwise identical.

Decomposition:
- Shared package/header (head.v):
  - LABEL_W, DATA_W defaults.
  - Constant NO_LABEL = 0.
  - Source index constants SRC_ADD=0, SRC_MUL=1, SRC_LD=2.
- One sub-module: rr_pick, a combinational rotate-priority-encoder.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: one-hot grant and encoded index.
- Registers and counters stay in cdb_arbiter.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with all sources valid -> req_grant=0, BCEN=0, BClabel=0, BCdata=0; after release, first grant goes to source 0.
- Single requester: src1 valid with label 5, data 32'hDEADBEEF -> req_grant=3'b010 that cycle; next cycle BCEN=1, BClabel=5, BCdata=32'hDEADBEEF; following cycle BCEN=0.
- Round-robin: all 3 sources valid continuously, labels 1/2/3 -> grants 0,1,2,0,1,2 on consecutive cycles; BCEN=1 every cycle; each grant appears on the CDB one cycle later.
- Holding: src0 and src2 valid with rr_ptr=2 -> src2 granted first; src0 (label 1, data 7, held stable) granted next cycle and broadcast the cycle after.
- Label 0 request: src1 valid with label 0, nothing else -> no grant, BCEN stays 0, rr_ptr unchanged; src0 requests later and is granted normally.
- CDB_STATS_EN: 3 cycles of full conflict, then 2 cycles with a single requester -> stat_conflict=3, stat_grants={2,2,1} (src0..src2 pattern per rr order); a saturation test preloads 16'hFFFE and shows the counter holds at 16'hFFFF.
